// File: rtl/training_data_feeder.sv
// training_data_feeder
//   Holds a small table of training samples and streams them to a neuron,
//   one sample per accepted cycle, wrapping every nBus samples (one epoch).
//   A session ends when the neuron reports convergence (done) or when the
//   epoch limit is reached.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst             : synchronous reset, active low
//   go              : session start request (honoured in IDLE / FINISH)
//   nCfg            : samples per epoch, legal range 1..DEPTH
//   maxEpochs       : epoch limit, 0 = unlimited
//   wrEn/wrAddr     : sample-memory write strobe and address
//   wrX1/wrX2/wrT   : sample-memory write data
//   readyToGetData  : neuron consumes the presented sample this cycle
//   done            : neuron reports convergence
//   X1Bus/X2Bus/tBus: presented sample
//   nBus            : latched samples-per-epoch
//   start           : neuron start pulse (2 cycles)
//   busy/finished   : session running / session ended
//   error           : bad configuration or epoch limit hit
//   epochCount      : completed epochs (saturating)
module training_data_feeder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [31:0]   nCfg,
  input  logic [15:0]   maxEpochs,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [6:0]    wrX1,
  input  logic [6:0]    wrX2,
  input  logic [1:0]    wrT,
  input  logic          readyToGetData,
  input  logic          done,
  output logic [6:0]    X1Bus,
  output logic [6:0]    X2Bus,
  output logic [1:0]    tBus,
  output logic [31:0]   nBus,
  output logic          start,
  output logic          busy,
  output logic          finished,
  output logic          error,
  output logic [15:0]   epochCount
);

  typedef enum logic [1:0] {IDLE, START, FEED, FINISH} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;
  logic [15:0]   r_epoch;
  logic [15:0]   w_epoch_next;
  logic [15:0]   w_epoch_inc;
  logic [31:0]   r_n;
  logic [31:0]   w_n_next;
  logic          r_error;
  logic          w_error_next;
  logic          r_start_cnt;
  logic          w_start_cnt_next;
  logic          w_load;
  logic          w_last;
  logic          w_cfg_ok;
  logic          w_wr_ok;
  logic [15:0]   r_sample;

  // Entry layout: {X1[6:0], X2[6:0], T[1:0]}
  logic [15:0]   r_mem [DEPTH];

  // The table may only change while no session is running, so the
  // presented sample can never be corrupted mid-epoch.
  assign w_wr_ok = wrEn && ((r_state == IDLE) || (r_state == FINISH));

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wrAddr] <= {wrX1, wrX2, wrT};
    end
  end

  // Registered read addressed by the *next* index: the sample for the
  // following cycle is fetched on the same edge that accepts the current
  // one, which gives zero-bubble streaming. Held when nothing is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sample <= 16'd0;
    end else if (w_load) begin
      r_sample <= r_mem[w_idx_next];
    end
  end

  assign w_cfg_ok    = (nCfg != 32'd0) && (nCfg <= 32'(DEPTH));
  assign w_last      = (32'(r_idx) == (r_n - 32'd1));
  assign w_epoch_inc = (r_epoch == 16'hFFFF) ? r_epoch : (r_epoch + 16'd1);

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_epoch_next     = r_epoch;
    w_n_next         = r_n;
    w_error_next     = r_error;
    w_start_cnt_next = r_start_cnt;
    w_load           = 1'b0;
    start            = 1'b0;
    busy             = 1'b0;
    finished         = 1'b0;

    case (r_state)
      IDLE, FINISH: begin
        finished = (r_state == FINISH);
        if (go) begin
          if (w_cfg_ok) begin
            w_n_next         = nCfg;
            w_idx_next       = '0;
            w_epoch_next     = 16'd0;
            w_error_next     = 1'b0;
            w_start_cnt_next = 1'b0;
            w_state_next     = START;
          end else begin
            w_error_next = 1'b1;
            w_state_next = FINISH;
          end
        end
      end

      START: begin
        start = 1'b1;
        busy  = 1'b1;
        if (r_start_cnt) begin
          // Prefetch mem[0] so it is on the bus in the first FEED cycle.
          w_load       = 1'b1;
          w_state_next = FEED;
        end else begin
          w_start_cnt_next = 1'b1;
        end
      end

      FEED: begin
        busy = 1'b1;
        if (done) begin
          // Convergence wins over a coincident accept; that sample is not
          // counted and the bus keeps showing it.
          w_error_next = 1'b0;
          w_state_next = FINISH;
        end else if (readyToGetData) begin
          if (w_last) begin
            w_idx_next   = '0;
            w_epoch_next = w_epoch_inc;
            if ((maxEpochs != 16'd0) && (w_epoch_inc == maxEpochs)) begin
              // Limit hit: keep the last accepted sample on the bus.
              w_error_next = 1'b1;
              w_state_next = FINISH;
            end else begin
              w_load = 1'b1;
            end
          end else begin
            w_idx_next = r_idx + {{(AW-1){1'b0}}, 1'b1};
            w_load     = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_epoch     <= 16'd0;
      r_n         <= 32'd0;
      r_error     <= 1'b0;
      r_start_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_epoch     <= w_epoch_next;
      r_n         <= w_n_next;
      r_error     <= w_error_next;
      r_start_cnt <= w_start_cnt_next;
    end
  end

  assign X1Bus      = r_sample[15:9];
  assign X2Bus      = r_sample[8:2];
  assign tBus       = r_sample[1:0];
  assign nBus       = r_n;
  assign error      = r_error;
  assign epochCount = r_epoch;

endmodule

// File: tb/tb_training_data_feeder.sv
module tb_training_data_feeder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [31:0]   nCfg = 32'd0;
  logic [15:0]   maxEpochs = 16'd0;
  logic          wrEn = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [6:0]    wrX1 = 7'd0;
  logic [6:0]    wrX2 = 7'd0;
  logic [1:0]    wrT = 2'd0;
  logic          readyToGetData = 1'b0;
  logic          done = 1'b0;
  logic [6:0]    X1Bus;
  logic [6:0]    X2Bus;
  logic [1:0]    tBus;
  logic [31:0]   nBus;
  logic          start;
  logic          busy;
  logic          finished;
  logic          error;
  logic [15:0]   epochCount;

  always #5 clk = ~clk;

  training_data_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .nCfg(nCfg), .maxEpochs(maxEpochs),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2), .wrT(wrT),
    .readyToGetData(readyToGetData), .done(done),
    .X1Bus(X1Bus), .X2Bus(X2Bus), .tBus(tBus), .nBus(nBus),
    .start(start), .busy(busy), .finished(finished), .error(error),
    .epochCount(epochCount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [15:0] m_mem [DEPTH];
  logic [15:0] exp_q[$];
  int          m_idx, m_epoch, m_n, m_maxe;
  bit          m_in_feed;
  bit          m_err;
  logic [15:0] m_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] bus_now();
    return {X1Bus, X2Bus, tBus};
  endfunction

  // All tasks are entered and left at a falling edge.
  task automatic write_mem(input int addr, input logic [6:0] x1, input logic [6:0] x2, input logic [1:0] t);
    wrEn = 1'b1; wrAddr = AW'(addr); wrX1 = x1; wrX2 = x2; wrT = t;
    @(negedge clk);
    wrEn = 1'b0;
    m_mem[addr] = {x1, x2, t};
    $display("[TB] write mem[%0d] = %h", addr, {x1, x2, t});
  endtask

  task automatic start_session(input int n, input int maxe);
    go = 1'b1; nCfg = 32'(n); maxEpochs = 16'(maxe);
    @(negedge clk);
    go = 1'b0;
    check("start_c1", 32'(start), 32'd1);
    check("busy_start", 32'(busy), 32'd1);
    check("nbus_c1", nBus, 32'(n));
    check("err_clr", 32'(error), 32'd0);
    @(negedge clk);
    check("start_c2", 32'(start), 32'd1);
    check("nbus_c2", nBus, 32'(n));
    @(negedge clk);
    check("start_off", 32'(start), 32'd0);
    check("busy_feed", 32'(busy), 32'd1);
    m_n = n; m_maxe = maxe; m_idx = 0; m_epoch = 0; m_in_feed = 1'b1; m_err = 1'b0;
    exp_q.delete();
    exp_q.push_back(m_mem[0]);
    $display("[TB] session n=%0d maxEpochs=%0d started", n, maxe);
  endtask

  task automatic feed_step(input bit rdy, input bit dn, input bit wr);
    logic [15:0] e;
    e = 16'd0;
    if (exp_q.size() == 0) check("q_empty", 32'd0, 32'd1);
    else e = exp_q.pop_front();
    check("sample", 32'(bus_now()), 32'(e));
    check("epoch", 32'(epochCount), 32'(m_epoch));
    m_cur = e;
    $display("[TB] feed idx=%0d rdy=%0d done=%0d sample=%h epoch=%0d", m_idx, rdy, dn, bus_now(), epochCount);
    readyToGetData = rdy; done = dn;
    wrEn = wr; wrAddr = '0; wrX1 = 7'h2A; wrX2 = 7'h15; wrT = 2'b10;
    if (dn) begin
      m_in_feed = 1'b0;
      m_err = 1'b0;
      exp_q.push_back(m_cur);
    end else if (rdy) begin
      if (m_idx == m_n - 1) begin
        m_idx = 0;
        if (m_epoch < 65535) m_epoch++;
        if (m_maxe != 0 && m_epoch == m_maxe) begin
          m_in_feed = 1'b0;
          m_err = 1'b1;
        end
      end else begin
        m_idx++;
      end
      if (m_in_feed) exp_q.push_back(m_mem[m_idx]);
      else exp_q.push_back(m_cur);
    end else begin
      exp_q.push_back(m_cur);
    end
    @(negedge clk);
    readyToGetData = 1'b0; done = 1'b0; wrEn = 1'b0;
  endtask

  task automatic check_finish();
    logic [15:0] e;
    e = 16'd0;
    if (exp_q.size() == 0) check("q_empty_fin", 32'd0, 32'd1);
    else e = exp_q.pop_front();
    check("hold_sample", 32'(bus_now()), 32'(e));
    check("finished", 32'(finished), 32'd1);
    check("busy_fin", 32'(busy), 32'd0);
    check("start_fin", 32'(start), 32'd0);
    check("error_fin", 32'(error), 32'(m_err));
    check("epoch_fin", 32'(epochCount), 32'(m_epoch));
    $display("[TB] finish error=%0d epoch=%0d sample=%h", error, epochCount, bus_now());
    // ready/done while finished must change nothing
    readyToGetData = 1'b1; done = 1'b1;
    @(negedge clk);
    readyToGetData = 1'b0; done = 1'b0;
    check("fin_ign_sample", 32'(bus_now()), 32'(e));
    check("fin_ign_epoch", 32'(epochCount), 32'(m_epoch));
    check("fin_ign_finished", 32'(finished), 32'd1);
    check("fin_ign_error", 32'(error), 32'(m_err));
  endtask

  task automatic bad_go(input int n);
    go = 1'b1; nCfg = 32'(n);
    @(negedge clk);
    go = 1'b0;
    check("bad_finished", 32'(finished), 32'd1);
    check("bad_error", 32'(error), 32'd1);
    check("bad_start", 32'(start), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("bad_start_later", 32'(start), 32'd0);
    check("bad_finished_later", 32'(finished), 32'd1);
    $display("[TB] bad go nCfg=%0d error=%0d finished=%0d", n, error, finished);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"}, 32'(bus_now()), 32'd0);
    check({tag, "_nbus"}, nBus, 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_finished"}, 32'(finished), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_epoch"}, 32'(epochCount), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    write_mem(0, 7'h70, 7'h70, 2'b11);
    write_mem(1, 7'h05, 7'h0A, 2'b01);
    write_mem(2, 7'h7F, 7'h00, 2'b00);

    // Continuous streaming, then done coincident with ready at idx=1
    start_session(3, 0);
    for (int i = 0; i < 7; i++) feed_step(1'b1, 1'b0, 1'b0);
    check("idx_before_done", 32'(m_idx), 32'd1);
    feed_step(1'b1, 1'b1, 1'b0);
    check_finish();

    // Ready toggling 1,0,0,1,1
    start_session(3, 0);
    feed_step(1'b1, 1'b0, 1'b0);
    feed_step(1'b0, 1'b0, 1'b0);
    feed_step(1'b0, 1'b0, 1'b0);
    feed_step(1'b1, 1'b0, 1'b0);
    feed_step(1'b1, 1'b0, 1'b0);
    feed_step(1'b0, 1'b1, 1'b0);
    check_finish();

    // Epoch limit
    start_session(3, 2);
    for (int i = 0; i < 20 && m_in_feed; i++) feed_step(1'b1, 1'b0, 1'b0);
    if (m_in_feed) check("limit_timeout", 32'd0, 32'd1);
    check_finish();

    // Illegal configurations
    bad_go(0);
    bad_go(65);

    // Upper boundary nCfg = DEPTH is legal and clears the error
    start_session(DEPTH, 0);
    feed_step(1'b0, 1'b1, 1'b0);
    check_finish();

    // Writes ignored while feeding; reset mid-FEED; replay
    start_session(3, 0);
    feed_step(1'b1, 1'b0, 1'b0);
    feed_step(1'b1, 1'b0, 1'b1);
    feed_step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    $display("[TB] reset mid-feed");
    rst = 1'b1;
    start_session(3, 0);
    for (int i = 0; i < 4; i++) feed_step(1'b1, 1'b0, 1'b0);
    feed_step(1'b0, 1'b1, 1'b0);
    check_finish();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/training_data_feeder.md
TRAINING_DATA_FEEDER -- requirements
Module: training_data_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 64: sample memory depth.
REQ-002 SHALL have parameter AW, default 6: memory address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port go, input, 1 bit: session start request.
REQ-006 SHALL have port nCfg, input, 32 bits: samples per epoch.
REQ-007 SHALL have port maxEpochs, input, 16 bits: epoch limit; 0 = unlimited.
REQ-008 SHALL have ports wrEn, input, 1 bit, and wrAddr, input, AW bits: sample-memory write.
REQ-009 SHALL have ports wrX1, input, 7 bits; wrX2, input, 7 bits; wrT, input, 2 bits: sample-memory write data.
REQ-010 SHALL have port readyToGetData, input, 1 bit: neuron accepts the presented sample this cycle.
REQ-011 SHALL have port done, input, 1 bit: neuron training converged.
REQ-012 SHALL have ports X1Bus, output, 7 bits; X2Bus, output, 7 bits; tBus, output, 2 bits: presented sample.
REQ-013 SHALL have port nBus, output, 32 bits: sample count to neuron.
REQ-014 SHALL have port start, output, 1 bit: neuron start.
REQ-015 SHALL have ports busy, output, 1 bit; finished, output, 1 bit; error, output, 1 bit: status.
REQ-016 SHALL have port epochCount, output, 16 bits: completed epochs.

Function
REQ-017 SHALL implement FSM states IDLE, START, FEED, FINISH.
REQ-018 Memory: SHALL perform an entry write {X1,X2,T} at wrAddr on a wrEn edge only in IDLE or FINISH; SHALL ignore wrEn in START and FEED.
REQ-019 IDLE: on go=1 with 1<=nCfg<=DEPTH, SHALL latch nCfg into nBus, clear idx and epochCount, and go to START.
REQ-020 IDLE: on go=1 with nCfg=0 or nCfg>DEPTH, SHALL set error=1 and go to FINISH, never asserting start.
REQ-021 START: SHALL last exactly 2 cycles with start=1 and nBus stable, then go to FEED with start=0.
REQ-022 FEED: SHALL drive X1Bus/X2Bus/tBus from registers equal to mem[idx], updated on the edge after each acceptance.
REQ-023 Acceptance SHALL be the rising edge with readyToGetData=1 in FEED, giving at most one sample consumed per cycle.
REQ-024 Back-to-back acceptance SHALL present mem[idx+1] in the very next cycle (zero bubble).
REQ-025 On acceptance with idx=nBus-1, idx SHALL wrap to 0 and epochCount SHALL increment, saturating at 16'hFFFF.
REQ-026 If the increment makes epochCount equal a nonzero maxEpochs, SHALL go to FINISH with error=1 (limit hit, not converged).
REQ-027 done=1 in FEED SHALL go to FINISH with error=0, taking priority over a simultaneous readyToGetData (that sample not counted).
REQ-028 done=1 outside FEED SHALL be ignored.
REQ-029 readyToGetData outside FEED SHALL be ignored.
REQ-030 busy SHALL be 1 in START and FEED; finished SHALL be 1 only in FINISH.
REQ-031 FINISH: SHALL hold epochCount, nBus, error and the last presented sample; go=1 SHALL behave as in IDLE (REQ-019/020) and clear error.
REQ-032 go while busy SHALL be ignored.

Reset
REQ-033 rst=0 at an edge SHALL, from any state, force IDLE and drive X1Bus=0, X2Bus=0, tBus=0, nBus=0, start=0, busy=0, finished=0, error=0, epochCount=0, idx=0.
REQ-034 Reset SHALL NOT clear sample-memory contents.
REQ-035 Reset mid-FEED SHALL drop start and busy in the cycle after the reset edge.

Verification
REQ-036 Load mem[0..2]=(7'h70,7'h70,2'b11),(7'h05,7'h0A,2'b01),(7'h7F,7'h00,2'b00); nCfg=3, go; ready held 1 -> start=1 for 2 cycles, then samples 0,1,2,0,... one per cycle, epochCount increments every 3 acceptances.
REQ-037 Ready toggled 1,0,0,1 -> outputs hold mem[idx] during low cycles; idx advances only on high cycles.
REQ-038 nCfg=3, maxEpochs=2, done never -> FINISH after 6 acceptances with epochCount=2, error=1, finished=1.
REQ-039 done=1 coincident with ready at idx=1 -> FINISH, error=0, epochCount unchanged, idx not advanced.
REQ-040 go with nCfg=0, then go with nCfg=65 -> each yields error=1, finished=1, start never asserted.
REQ-041 rst=0 mid-FEED, then go again with the same memory -> all outputs 0 after reset; restarted session replays from mem[0] with identical data.
